// File: rtl/div_pkg.sv
// Shared constants, state encoding and control decode for the divider control.
// Optional macro DIV_ZERO_DETECT_EN is handled in the interface and top.
package div_pkg;

   localparam int DIV_WIDTH = 32;
   localparam int CNT_WIDTH = 6;

   typedef enum logic [2:0] {
      IDLE,
      INIT,
      ITER,
      FIX,
      DONE
   } div_state_t;

   // Per-state control bits held in flops alongside the state.
   typedef struct packed {
      logic srl;
      logic sll;
      logic w_init;
      logic iter;
      logic busy;
      logic ready;
   } div_ctrl_t;

   function automatic div_ctrl_t ctrl_of(div_state_t s);
      div_ctrl_t c;
      c = '0;
      unique case (s)
         INIT: begin
            c.w_init = 1'b1;
            c.sll    = 1'b1;
            c.busy   = 1'b1;
         end
         ITER: begin
            c.iter = 1'b1;
            c.sll  = 1'b1;
            c.busy = 1'b1;
         end
         FIX: begin
            c.srl  = 1'b1;
            c.busy = 1'b1;
         end
         DONE: c.ready = 1'b1;
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/divider_control_if.sv
// Handshake/control bundle between requester, divisor ALU and Remainder register.
// With DIV_ZERO_DETECT_EN defined, adds divisor_zero and div_zero.
interface divider_control_if;

   logic run;
   logic ALU_Carry;
   logic srl_ctrl;
   logic sll_ctrl;
   logic w_ctrl;
   logic alu_sub;
   logic busy;
   logic ready;
`ifdef DIV_ZERO_DETECT_EN
   logic divisor_zero;
   logic div_zero;

   modport master (
      output run, ALU_Carry, divisor_zero,
      input  srl_ctrl, sll_ctrl, w_ctrl,
      input  alu_sub, busy, ready, div_zero
   );

   modport slave (
      input  run, ALU_Carry, divisor_zero,
      output srl_ctrl, sll_ctrl, w_ctrl,
      output alu_sub, busy, ready, div_zero
   );
`else
   modport master (
      output run, ALU_Carry,
      input  srl_ctrl, sll_ctrl, w_ctrl,
      input  alu_sub, busy, ready
   );

   modport slave (
      input  run, ALU_Carry,
      output srl_ctrl, sll_ctrl, w_ctrl,
      output alu_sub, busy, ready
   );
`endif

endinterface

// File: rtl/div_iter_counter.sv
// Iteration counter: cleared while loading, counts during iterations,
// flags the last iteration (DIV_WIDTH-1).
module div_iter_counter
   import div_pkg::*;
#(
   parameter int DW = DIV_WIDTH,
   parameter int CW = CNT_WIDTH
) (
   input  logic clk,
   input  logic reset,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   localparam logic [CW-1:0] LAST = CW'(DW - 1);

   // Next count: clear has priority, otherwise step when enabled.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Count register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = (cnt_q == LAST);

endmodule

// File: rtl/divider_control.sv
// Control FSM for the sequential restoring divider (load, iterate, fix, done).
// Optional macro DIV_ZERO_DETECT_EN: zero divisor short-circuits to DONE.
module divider_control
   import div_pkg::*;
#(
   parameter int DIV_WIDTH = div_pkg::DIV_WIDTH,
   parameter int CNT_WIDTH = div_pkg::CNT_WIDTH
) (
   input logic              clk,
   input logic              reset,
   divider_control_if.slave bus
);

   div_state_t state_q;
   div_state_t state_d;
   div_ctrl_t  ctrl_q;
   div_ctrl_t  ctrl_d;
   logic       run_d_q;
   logic       start;
   logic       tc;
   logic       dz_q;
   logic       dz_d;

   assign start = bus.run & ~run_d_q;

   div_iter_counter #(
      .DW (DIV_WIDTH),
      .CW (CNT_WIDTH)
   ) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clr_i (state_q == INIT),
      .en_i  (state_q == ITER),
      .tc_o  (tc)
   );

   // Next state; control bits are decoded from it so they register with it.
   always_comb begin
      state_d = state_q;
      dz_d    = dz_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = INIT;
               dz_d    = 1'b0;
`ifdef DIV_ZERO_DETECT_EN
               if (bus.divisor_zero) begin
                  state_d = DONE;
                  dz_d    = 1'b1;
               end
`endif
            end
         end
         INIT: state_d = ITER;
         ITER: if (tc) state_d = FIX;
         FIX:  state_d = DONE;
         default: state_d = IDLE;
      endcase
      ctrl_d = ctrl_of(state_d);
   end

   // State, control and run-edge registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         ctrl_q  <= '0;
         run_d_q <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
         run_d_q <= bus.run;
         dz_q    <= dz_d;
      end
   end

   // w_ctrl follows the borrow-free flag directly during iterations.
   assign bus.srl_ctrl = ctrl_q.srl;
   assign bus.sll_ctrl = ctrl_q.sll;
   assign bus.w_ctrl   = ctrl_q.w_init
                       | (ctrl_q.iter & bus.ALU_Carry);
   assign bus.alu_sub  = ctrl_q.iter;
   assign bus.busy     = ctrl_q.busy;
   assign bus.ready    = ctrl_q.ready;
`ifdef DIV_ZERO_DETECT_EN
   assign bus.div_zero = dz_q;
`else
   logic unused_dz;
   assign unused_dz = dz_q;
`endif

endmodule

// File: tb/tb_divider_control.sv
// Self-checking bench for divider_control: vector table plus
// multi-cycle sequences with a behavioural Remainder/ALU model.
module tb_divider_control;

   logic clk;
   logic reset;
   logic force_c;
   logic use_model;
   logic model_c;
   logic dz;
   logic [63:0] rem;
   logic [31:0] dvs;
   logic [31:0] dvd;
   int total;
   int passed;

   divider_control_if dif ();

   divider_control dut (
      .clk   (clk),
      .reset (reset),
      .bus   (dif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign model_c = (rem[63:32] >= dvs);
   assign dif.ALU_Carry = use_model ? model_c : force_c;
`ifdef DIV_ZERO_DETECT_EN
   assign dif.divisor_zero = dz;
`endif

   // Behavioural Remainder register + divisor ALU.
   always @(posedge clk) begin
      if (dif.srl_ctrl) begin
         rem[63:32] <= rem[63:32] >> 1;
      end else if (dif.alu_sub) begin
         rem <= ({(dif.w_ctrl ? rem[63:32] - dvs
                              : rem[63:32]),
                  rem[31:0]} << 1)
              | {63'd0, dif.ALU_Carry};
      end else if (dif.w_ctrl) begin
         rem <= {32'd0, dvd} << 1;
      end
   end

   localparam logic [5:0] O_IDLE = 6'b000000;
   localparam logic [5:0] O_INIT = 6'b011010;
   localparam logic [5:0] O_IT0  = 6'b010110;
   localparam logic [5:0] O_IT1  = 6'b011110;
   localparam logic [5:0] O_FIX  = 6'b100010;
   localparam logic [5:0] O_DONE = 6'b000001;

   typedef struct {
      string      nm;
      logic       rst;
      logic       run;
      logic       c;
      logic [5:0] exp;
   } vec_t;

   vec_t vt [10];

   function automatic logic [5:0] outs();
      return {dif.srl_ctrl, dif.sll_ctrl, dif.w_ctrl,
              dif.alu_sub, dif.busy, dif.ready};
   endfunction

   task automatic chk(input string nm, input logic [5:0] exp);
      logic [5:0] act;
      act = outs();
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s outs=%b expected=%b", nm, act, exp);
   endtask

   task automatic chk_int(input string nm, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s got=%0d expected=%0d", nm, act, exp);
   endtask

   task automatic chk64(input string nm, input logic [63:0] exp);
      total++;
      if (rem === exp) passed++;
      else $display("FAIL %s rem=%h expected=%h", nm, rem, exp);
   endtask

   // Start one op from IDLE/DONE; returns edges to ready, w count in
   // iterations, invariant violations and ready seen in the INIT cycle.
   task automatic run_op(input bit hold, output int lat,
                         output int wcnt, output int viol,
                         output int rdy0);
      lat  = 0;
      wcnt = 0;
      viol = 0;
      dif.run = 1'b1;
      @(posedge clk); #1;
      if (!hold) dif.run = 1'b0;
      rdy0 = int'(dif.ready);
      while (lat < 100) begin
         if (dif.srl_ctrl && dif.sll_ctrl) viol++;
         if (dif.w_ctrl && !dif.sll_ctrl) viol++;
         if (dif.alu_sub && dif.w_ctrl) wcnt++;
         @(posedge clk); #1;
         lat++;
         if (dif.ready) break;
      end
   endtask

   initial begin
      int lat, wcnt, viol, rdy0, hits;
      total = 0;
      passed = 0;
      reset = 1'b0;
      dif.run = 1'b1;
      force_c = 1'b0;
      use_model = 1'b0;
      dz = 1'b0;
      dvs = 32'd1;
      dvd = 32'd0;
      @(posedge clk); #1;

      vt[0] = '{"rst_a",    1'b0, 1'b1, 1'b0, O_IDLE};
      vt[1] = '{"rst_b",    1'b0, 1'b1, 1'b0, O_IDLE};
      vt[2] = '{"rst_c",    1'b0, 1'b1, 1'b1, O_IDLE};
      vt[3] = '{"rel_a",    1'b1, 1'b0, 1'b1, O_IDLE};
      vt[4] = '{"rel_b",    1'b1, 1'b0, 1'b0, O_IDLE};
      vt[5] = '{"start",    1'b1, 1'b1, 1'b0, O_IDLE};
      vt[6] = '{"init",     1'b1, 1'b0, 1'b1, O_INIT};
      vt[7] = '{"iter0_c0", 1'b1, 1'b0, 1'b0, O_IT0};
      vt[8] = '{"iter1_c1", 1'b1, 1'b0, 1'b1, O_IT1};
      vt[9] = '{"iter2_c0", 1'b1, 1'b0, 1'b0, O_IT0};

      for (int i = 0; i < 10; i++) begin
         reset   = vt[i].rst;
         dif.run = vt[i].run;
         force_c = vt[i].c;
         #1;
         chk(vt[i].nm, vt[i].exp);
         @(posedge clk); #1;
      end

      // Remaining iterations with toggling carry: w mirrors it.
      for (int k = 3; k < 32; k++) begin
         force_c = k[0];
         #1;
         chk("iter_follow", {1'b0, 1'b1, k[0], 1'b1, 1'b1, 1'b0});
         @(posedge clk); #1;
      end
      force_c = 1'b1;
      #1;
      chk("fix", O_FIX);
      @(posedge clk); #1;
      chk("done", O_DONE);
      @(posedge clk); #1;
      chk("done_hold", O_DONE);

      // All-carry operation from DONE.
      force_c = 1'b1;
      run_op(1'b0, lat, wcnt, viol, rdy0);
      chk_int("retrig_rdy_drop", rdy0, 0);
      chk_int("lat_c1", lat, 34);
      chk_int("wcnt_c1", wcnt, 32);
      chk_int("invariant_c1", viol, 0);

      // Integration: 100 / 7.
      use_model = 1'b1;
      dvd = 32'd100;
      dvs = 32'd7;
      run_op(1'b0, lat, wcnt, viol, rdy0);
      chk_int("lat_100_7", lat, 34);
      chk64("rem_100_7", {32'd2, 32'd14});
      chk_int("invariant_100_7", viol, 0);

      // Integration: 0xFFFFFFFF / 1.
      dvd = 32'hFFFF_FFFF;
      dvs = 32'd1;
      run_op(1'b0, lat, wcnt, viol, rdy0);
      chk_int("lat_ff_1", lat, 34);
      chk64("rem_ff_1", {32'd0, 32'hFFFF_FFFF});
      chk_int("wcnt_ff_1", wcnt, 32);
      use_model = 1'b0;

      // Mid-operation reset at iteration count 10.
      force_c = 1'b0;
      dif.run = 1'b1;
      @(posedge clk); #1;
      dif.run = 1'b0;
      repeat (11) @(posedge clk);
      #1;
      chk("midop_iter", O_IT0);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("midop_rst", O_IDLE);
      reset = 1'b1;
      hits = 0;
      for (int k = 0; k < 40; k++) begin
         if (dif.ready || dif.busy) hits++;
         @(posedge clk); #1;
      end
      chk_int("midop_quiet", hits, 0);
      run_op(1'b0, lat, wcnt, viol, rdy0);
      chk_int("lat_after_rst", lat, 34);

      // Held run: one operation only, then retrigger.
      run_op(1'b1, lat, wcnt, viol, rdy0);
      chk_int("lat_held", lat, 34);
      repeat (5) @(posedge clk);
      #1;
      chk("held_no_retrig", O_DONE);
      dif.run = 1'b0;
      @(posedge clk); #1;
      run_op(1'b0, lat, wcnt, viol, rdy0);
      chk_int("retrig2_rdy_drop", rdy0, 0);
      chk_int("lat_retrig", lat, 34);

`ifdef DIV_ZERO_DETECT_EN
      dz = 1'b1;
      dif.run = 1'b1;
      @(posedge clk); #1;
      dif.run = 1'b0;
      chk("dz_done", O_DONE);
      chk_int("dz_flag", int'(dif.div_zero), 1);
      dz = 1'b0;
      run_op(1'b0, lat, wcnt, viol, rdy0);
      chk_int("dz_lat_normal", lat, 34);
      chk_int("dz_flag_clr", int'(dif.div_zero), 0);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
